// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: word RAM with byte-lane writes and 1-cycle read-first reads,
// plus an MMIO window holding LED, free-running timer and scratch registers.
module data_sram_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [15:0] MMIO_HI    = 16'hbfaf,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [3:0]  wen_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [15:0] led_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  localparam logic [15:0] OffLed     = 16'h0000;
  localparam logic [15:0] OffTimer   = 16'h0004;
  localparam logic [15:0] OffScratch = 16'h0008;

  logic [31:0] mem_q [Depth];

  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] scratch_q, scratch_d;

  logic                  is_mmio;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [15:0]           offset;
  logic                  wr_en;
  logic                  ram_we, led_we, timer_we, scratch_we;
  logic [31:0]           mmio_rdata;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign is_mmio    = (addr_i[31:16] == MMIO_HI);
  assign word_idx   = addr_i[ADDR_WIDTH+1:2];
  assign offset     = addr_i[15:0];
  assign wr_en      = en_i && (wen_i != 4'h0);
  assign ram_we     = wr_en && !is_mmio;
  assign led_we     = wr_en && is_mmio && (offset == OffLed);
  assign timer_we   = wr_en && is_mmio && (offset == OffTimer);
  assign scratch_we = wr_en && is_mmio && (offset == OffScratch);

  always_comb begin
    case (offset)
      OffLed:     mmio_rdata = {16'h0000, led_q};
      OffTimer:   mmio_rdata = timer_q;
      OffScratch: mmio_rdata = scratch_q;
      default:    mmio_rdata = 32'h0;
    endcase
  end

  always_comb begin
    led_d     = led_q;
    timer_d   = timer_q + 32'd1;
    scratch_d = scratch_q;
    rdata_d   = rdata_q;
    // LED only has the two low byte lanes; upper enables fall away here.
    if (led_we) begin
      if (wen_i[0]) led_d[7:0]  = wdata_i[7:0];
      if (wen_i[1]) led_d[15:8] = wdata_i[15:8];
    end
    // A timer write replaces the increment for that cycle.
    if (timer_we)   timer_d   = byte_merge(timer_q, wdata_i, wen_i);
    if (scratch_we) scratch_d = byte_merge(scratch_q, wdata_i, wen_i);
    if (en_i)       rdata_d   = is_mmio ? mmio_rdata : mem_q[word_idx];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q   <= 32'h0;
      led_q     <= 16'h0;
      timer_q   <= 32'h0;
      scratch_q <= 32'h0;
    end else begin
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      timer_q   <= timer_d;
      scratch_q <= scratch_d;
    end
  end

  // RAM array has no reset so it maps onto block memory.
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wen_i[i]) mem_q[word_idx][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;
  assign led_o   = led_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: RAM read-first/byte writes, hold, aliasing, MMIO, reset.
module tb_data_sram_responder;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] led;

  int checks = 0;
  int passes = 0;

  data_sram_responder dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (en),
    .wen_i   (wen),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .led_o   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one access, take the edge, then settle 1 ns past it.
  task automatic access(input logic e, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0);
    else passes++;
    checks++;
    if (led !== 16'h0) $display("FAIL reset_led: got %h want %h", led, 16'h0);
    else passes++;
  endtask

  task automatic test_timer();
    rst_n = 1'b1;
    repeat (10) access(1'b0, 4'h0, 32'h0, 32'h0);
    access(1'b1, 4'h0, 32'hbfaf0004, 32'h0);
    checks++;
    if (rdata !== 32'd10) $display("FAIL timer_cycle10: got %h want %h", rdata, 32'd10);
    else passes++;
    access(1'b1, 4'hf, 32'hbfaf0004, 32'hfffffffe);
    access(1'b1, 4'h0, 32'hbfaf0004, 32'h0);
    checks++;
    if (rdata !== 32'hfffffffe) $display("FAIL timer_wr: got %h want %h", rdata, 32'hfffffffe);
    else passes++;
    access(1'b1, 4'h0, 32'hbfaf0004, 32'h0);
    checks++;
    if (rdata !== 32'hffffffff) $display("FAIL timer_inc: got %h want %h", rdata, 32'hffffffff);
    else passes++;
    access(1'b1, 4'h0, 32'hbfaf0004, 32'h0);
    checks++;
    if (rdata !== 32'h0) $display("FAIL timer_wrap: got %h want %h", rdata, 32'h0);
    else passes++;
  endtask

  task automatic test_ram_rw();
    access(1'b1, 4'hf, 32'h00000100, 32'h0);
    access(1'b1, 4'hf, 32'h00000100, 32'h12345678);
    checks++;
    if (rdata !== 32'h0) $display("FAIL wr_returns_old: got %h want %h", rdata, 32'h0);
    else passes++;
    access(1'b1, 4'h0, 32'h00000100, 32'h0);
    checks++;
    if (rdata !== 32'h12345678) $display("FAIL rd_0x100: got %h want %h", rdata, 32'h12345678);
    else passes++;
  endtask

  task automatic test_byte_write();
    access(1'b1, 4'b0010, 32'h00000100, 32'h0000ab00);
    access(1'b1, 4'h0, 32'h00000100, 32'h0);
    checks++;
    if (rdata !== 32'h1234ab78) $display("FAIL byte_wr: got %h want %h", rdata, 32'h1234ab78);
    else passes++;
    // Word index is addr[13:2]; bit 14 aliases back onto 0x100.
    access(1'b1, 4'h0, 32'h00004100, 32'h0);
    checks++;
    if (rdata !== 32'h1234ab78) $display("FAIL alias: got %h want %h", rdata, 32'h1234ab78);
    else passes++;
  endtask

  task automatic test_read_first();
    access(1'b1, 4'hf, 32'h00000200, 32'h0);
    access(1'b1, 4'hf, 32'h00000200, 32'hdeadbeef);
    checks++;
    if (rdata !== 32'h0) $display("FAIL read_first_old: got %h want %h", rdata, 32'h0);
    else passes++;
    access(1'b1, 4'h0, 32'h00000200, 32'h0);
    checks++;
    if (rdata !== 32'hdeadbeef) $display("FAIL read_first_new: got %h want %h", rdata, 32'hdeadbeef);
    else passes++;
  endtask

  task automatic test_hold();
    access(1'b1, 4'hf, 32'h00000300, 32'h55aa55aa);
    access(1'b1, 4'h0, 32'h00000300, 32'h0);
    checks++;
    if (rdata !== 32'h55aa55aa) $display("FAIL hold_rd: got %h want %h", rdata, 32'h55aa55aa);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 4'hf, 32'h00000300 + 32'(i) * 4, 32'h11111111);
      checks++;
      if (rdata !== 32'h55aa55aa)
        $display("FAIL hold_cycle%0d: got %h want %h", i, rdata, 32'h55aa55aa);
      else passes++;
    end
    access(1'b1, 4'h0, 32'h00000300, 32'h0);
    checks++;
    if (rdata !== 32'h55aa55aa) $display("FAIL en0_no_write: got %h want %h", rdata, 32'h55aa55aa);
    else passes++;
  endtask

  task automatic test_mmio();
    access(1'b1, 4'hf, 32'hbfaf0000, 32'hfffff00f);
    checks++;
    if (led !== 16'hf00f) $display("FAIL led_out: got %h want %h", led, 16'hf00f);
    else passes++;
    access(1'b1, 4'h0, 32'hbfaf0000, 32'h0);
    checks++;
    if (rdata !== 32'h0000f00f) $display("FAIL led_rd: got %h want %h", rdata, 32'h0000f00f);
    else passes++;
    access(1'b1, 4'hf, 32'hbfaf0010, 32'hcafef00d);
    access(1'b1, 4'h0, 32'hbfaf0010, 32'h0);
    checks++;
    if (rdata !== 32'h0) $display("FAIL unmapped_rd: got %h want %h", rdata, 32'h0);
    else passes++;
    access(1'b1, 4'hf, 32'hbfaf0008, 32'h11223344);
    access(1'b1, 4'b0101, 32'hbfaf0008, 32'haabbccdd);
    access(1'b1, 4'h0, 32'hbfaf0008, 32'h0);
    checks++;
    if (rdata !== 32'h11bb33dd) $display("FAIL scratch_rd: got %h want %h", rdata, 32'h11bb33dd);
    else passes++;
  endtask

  task automatic test_reset_mid();
    access(1'b1, 4'h0, 32'hbfaf0000, 32'h0);
    checks++;
    if (rdata !== 32'h0000f00f) $display("FAIL pre_reset_rd: got %h want %h", rdata, 32'h0000f00f);
    else passes++;
    en = 1'b1; wen = 4'h0; addr = 32'hbfaf0008;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rdata !== 32'h0) $display("FAIL mid_reset_rdata: got %h want %h", rdata, 32'h0);
    else passes++;
    checks++;
    if (led !== 16'h0) $display("FAIL mid_reset_led: got %h want %h", led, 16'h0);
    else passes++;
    en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    access(1'b1, 4'h0, 32'hbfaf0008, 32'h0);
    checks++;
    if (rdata !== 32'h0) $display("FAIL scratch_after_reset: got %h want %h", rdata, 32'h0);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_timer();
    test_ram_rw();
    test_byte_write();
    test_read_first();
    test_hold();
    test_mmio();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
